// File: rtl/tlc_pkg.sv
// Shared types and lamp encodings for the multi-phase traffic-light controller.
package tlc_pkg;

    localparam int unsigned LAMP_W = 3;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    // Lamp bits are {green, yellow, red}
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tlc_dwell_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count reads zero.
module tlc_dwell_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             c,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // No reset of its own: the owner drives load during reset
    always_ff @(posedge c) begin
        if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/tlc_multi_phase.sv
// Fixed-time round-robin traffic-light controller with pedestrian walk requests
// and an emergency flash mode; lamp outputs decode directly from registered state.
module tlc_multi_phase
    import tlc_pkg::*;
#(
    parameter  int unsigned N_APPROACH = 2,
    parameter  int unsigned CNT_W      = 8,
    parameter  int unsigned GREEN_T    = 20,
    parameter  int unsigned YELLOW_T   = 4,
    parameter  int unsigned ALLRED_T   = 2,
    parameter  int unsigned FLASH_T    = 8,
    localparam int unsigned IDX_W      = $clog2(N_APPROACH)
) (
    input  logic                         c,
    input  logic                         r,
    input  logic [N_APPROACH-1:0]        ped_req,
    input  logic                         flash,
    output logic [LAMP_W*N_APPROACH-1:0] colour,
    output logic [N_APPROACH-1:0]        walk,
    output logic [IDX_W-1:0]             active,
    output logic                         phase_go
);

    if (N_APPROACH < 2) begin : g_bad_n
        $error("tlc_multi_phase: N_APPROACH must be at least 2");
    end
    if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || FLASH_T < 1) begin : g_bad_t
        $error("tlc_multi_phase: every dwell time must be at least 1");
    end
    if ($clog2(GREEN_T) > CNT_W || $clog2(YELLOW_T) > CNT_W ||
        $clog2(ALLRED_T) > CNT_W || $clog2(FLASH_T) > CNT_W) begin : g_bad_w
        $error("tlc_multi_phase: CNT_W too narrow for a dwell time");
    end

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_APPROACH - 1);

    state_t                  state;
    logic [IDX_W-1:0]        act;
    logic [N_APPROACH-1:0]   pending;
    logic                    walk_now;
    logic                    first;
    logic                    toggle;
    logic                    t_load;
    logic [CNT_W-1:0]        t_val;
    logic                    t_exp;

    tlc_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .c        (c),
        .load     (t_load),
        .load_val (t_val),
        .dec      (1'b1),
        .expired  (t_exp)
    );

    // Timer reload on every state entry, and on each flash half-period
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        if (!r) begin
            t_load = 1'b1;
            t_val  = ALLRED_LD;
        end else begin
            case (state)
                ST_GREEN: if (t_exp || flash) begin
                    t_load = 1'b1;
                    t_val  = YELLOW_LD;
                end
                ST_YELLOW: if (t_exp) begin
                    t_load = 1'b1;
                    t_val  = ALLRED_LD;
                end
                ST_ALLRED: if (t_exp) begin
                    t_load = 1'b1;
                    t_val  = flash ? FLASH_LD : GREEN_LD;
                end
                default: if (!flash) begin
                    t_load = 1'b1;
                    t_val  = ALLRED_LD;
                end else if (t_exp) begin
                    t_load = 1'b1;
                    t_val  = FLASH_LD;
                end
            endcase
        end
    end

    always_ff @(posedge c) begin
        if (!r) begin
            state    <= ST_ALLRED;
            act      <= '0;
            pending  <= '0;
            walk_now <= 1'b0;
            first    <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            first   <= 1'b0;
            pending <= pending | ped_req;
            case (state)
                ST_GREEN: if (t_exp || flash) state <= ST_YELLOW;
                ST_YELLOW: if (t_exp) begin
                    state <= ST_ALLRED;
                    act   <= (act == LAST_IDX) ? '0 : act + IDX_W'(1);
                end
                ST_ALLRED: if (t_exp) begin
                    if (flash) begin
                        state  <= ST_FLASH;
                        toggle <= 1'b1;
                    end else begin
                        // Walk grant includes a request sampled on the entry edge itself
                        state    <= ST_GREEN;
                        first    <= 1'b1;
                        walk_now <= pending[act] | ped_req[act];
                        pending  <= (pending | ped_req) & ~(N_APPROACH'(1) << act);
                    end
                end
                default: if (!flash) begin
                    state  <= ST_ALLRED;
                    act    <= '0;
                    toggle <= 1'b0;
                end else if (t_exp) begin
                    toggle <= ~toggle;
                end
            endcase
        end
    end

    always_comb begin
        colour = '0;
        walk   = '0;
        for (int unsigned i = 0; i < N_APPROACH; i++) begin
            colour[LAMP_W*i +: LAMP_W] = LAMP_RED;
            case (state)
                ST_GREEN: if (act == IDX_W'(i)) begin
                    colour[LAMP_W*i +: LAMP_W] = LAMP_GRN;
                    walk[i]                    = walk_now;
                end
                ST_YELLOW: if (act == IDX_W'(i)) colour[LAMP_W*i +: LAMP_W] = LAMP_YEL;
                ST_FLASH: colour[LAMP_W*i +: LAMP_W] = toggle ? LAMP_YEL : LAMP_OFF;
                default: ;
            endcase
        end
    end

    assign active   = act;
    assign phase_go = first;

endmodule

// File: tb/tb_tlc_multi_phase.sv
// Randomised and directed bench for tlc_multi_phase against a phase/countdown reference model.
module tb_tlc_multi_phase;

    localparam int N  = 2;
    localparam int GT = 5;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int FT = 3;
    localparam int PH_G = 0, PH_Y = 1, PH_AR = 2, PH_F = 3;

    logic          c = 1'b0;
    logic          r;
    logic [N-1:0]  ped_req;
    logic          flash;
    logic [3*N-1:0] colour;
    logic [N-1:0]  walk;
    logic          active;
    logic          phase_go;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: phase, cycles left in it (T..1), flash age in cycles
    int m_ph, m_left, m_act, m_age;
    bit m_pend [N];
    bit m_walk, m_first;

    tlc_multi_phase #(
        .N_APPROACH (N),
        .CNT_W      (8),
        .GREEN_T    (GT),
        .YELLOW_T   (YT),
        .ALLRED_T   (AT),
        .FLASH_T    (FT)
    ) dut (
        .c        (c),
        .r        (r),
        .ped_req  (ped_req),
        .flash    (flash),
        .colour   (colour),
        .walk     (walk),
        .active   (active),
        .phase_go (phase_go)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_tick();
        bit req [N];
        for (int i = 0; i < N; i++) req[i] = m_pend[i] | ped_req[i];
        if (!r) begin
            m_ph = PH_AR; m_left = AT; m_act = 0; m_walk = 0; m_first = 0; m_age = 0;
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            return;
        end
        m_first = 0;
        case (m_ph)
            PH_G: if (flash || m_left == 1) begin m_ph = PH_Y; m_left = YT; end
                  else m_left--;
            PH_Y: if (m_left == 1) begin m_ph = PH_AR; m_left = AT; m_act = (m_act + 1) % N; end
                  else m_left--;
            PH_AR: if (m_left == 1) begin
                if (flash) begin
                    m_ph = PH_F; m_age = 0;
                end else begin
                    m_ph = PH_G; m_left = GT; m_first = 1;
                    m_walk = req[m_act];
                    req[m_act] = 0;
                end
            end else m_left--;
            default: if (!flash) begin m_ph = PH_AR; m_left = AT; m_act = 0; end
                     else m_age++;
        endcase
        for (int i = 0; i < N; i++) m_pend[i] = req[i];
    endtask

    task automatic check_outputs();
        logic [3*N-1:0] e_col;
        logic [N-1:0]   e_walk;
        logic [2:0]     lamp;
        e_col  = '0;
        e_walk = '0;
        for (int i = 0; i < N; i++) begin
            case (m_ph)
                PH_G:  e_col[3*i +: 3] = (i == m_act) ? 3'b100 : 3'b001;
                PH_Y:  e_col[3*i +: 3] = (i == m_act) ? 3'b010 : 3'b001;
                PH_AR: e_col[3*i +: 3] = 3'b001;
                default: e_col[3*i +: 3] = (((m_age / FT) % 2) == 0) ? 3'b010 : 3'b000;
            endcase
            e_walk[i] = (m_ph == PH_G) && (i == m_act) && m_walk;
            lamp = colour[3*i +: 3];
            chk("lamp_onehot", 32'($countones(lamp) <= 1), 32'd1);
        end
        chk("colour", 32'(colour), 32'(e_col));
        chk("walk", 32'(walk), 32'(e_walk));
        chk("active", 32'(active), 32'(m_act));
        chk("phase_go", 32'(phase_go), 32'(m_first));
    endtask

    task automatic step();
        @(posedge c);
        model_tick();
        @(negedge c);
        cyc++;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_until_go(input int a);
        int k = 0;
        while (!(m_first && m_act == a) && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) chk("sync_green", 32'd0, 32'd1);
    endtask

    task automatic run_until_yellow(input int a);
        int k = 0;
        while (!(m_ph == PH_Y && m_act == a) && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) chk("sync_yellow", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        r = 1'b0;
        run(2);
        r = 1'b1;
    endtask

    initial begin
        int last_go;
        r = 1'b0; ped_req = '0; flash = 1'b0;
        @(negedge c);

        // Plain round-robin, with phase_go spacing
        do_reset();
        last_go = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (phase_go) begin
                if (last_go >= 0) chk("go_gap", 32'(cyc - last_go), 32'd8);
                last_go = cyc;
            end
        end

        // Request for approach 1 during approach 0 green
        run_until_go(0);
        step();
        ped_req = 2'b10; step(); ped_req = '0;
        run(40);

        // Own-green request for approach 0 waits a full round
        run_until_go(0);
        ped_req = 2'b01; step(); ped_req = '0;
        run(40);

        // Flash raised in second cycle of approach 0 green
        run_until_go(0);
        step();
        flash = 1'b1;
        run(20);
        flash = 1'b0;
        run(20);

        // Reset mid-yellow of approach 1 with a request still pending
        run_until_go(0);
        ped_req = 2'b01; step(); ped_req = '0;
        run_until_yellow(1);
        r = 1'b0; step(); r = 1'b1;
        run(40);

        // Continuous requests on both approaches
        ped_req = 2'b11;
        run(60);
        ped_req = '0;

        // Randomised traffic, flash and occasional reset
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) ped_req[i] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) flash = ~flash;
            r = ($urandom_range(0, 299) != 0);
            step();
        end
        r = 1'b1; flash = 1'b0; ped_req = '0;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
